// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer for the IF stage.
// Gives a same-cycle next-PC prediction for the fetch PC.
// Trained from EX when a control-flow instruction resolves.
// Each entry holds a valid bit, tag, target and a 2-bit saturating direction counter.
module branch_target_buffer #(
    parameter int XLEN        = 32,
    parameter int INDEX_WIDTH = 5,
    parameter int TAG_WIDTH   = 25
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic [XLEN-1:0] pred_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_next_pc,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_is_branch,
    input  logic            upd_is_jump,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target
);

    localparam int DEPTH    = 1 << INDEX_WIDTH;
    localparam int IDX_LSB  = 2;
    localparam int IDX_MSB  = INDEX_WIDTH + 1;
    localparam int TAG_LSB  = INDEX_WIDTH + 2;
    localparam int TAG_MSB  = INDEX_WIDTH + TAG_WIDTH + 1;

    localparam logic [1:0] CNT_RESET = 2'b01;
    localparam logic [1:0] CNT_ALLOC = 2'b10;
    localparam logic [1:0] CNT_JUMP  = 2'b11;

    // The tag and index fields must fit inside the PC above the byte offset.
    if (INDEX_WIDTH + TAG_WIDTH + 2 > XLEN) begin : g_bad_params
        $error("branch_target_buffer: INDEX_WIDTH+TAG_WIDTH+2 exceeds XLEN");
    end

    // Classification of the resolved instruction; a jump wins over a branch.
    typedef enum logic [1:0] {
        UPD_IDLE,
        UPD_JUMP,
        UPD_BRANCH,
        UPD_OTHER
    } upd_kind_e;

    logic                   valid_q   [DEPTH];
    logic [TAG_WIDTH-1:0]   tag_q     [DEPTH];
    logic [XLEN-1:0]        target_q  [DEPTH];
    logic [1:0]             counter_q [DEPTH];

    logic [INDEX_WIDTH-1:0] pred_idx;
    logic [TAG_WIDTH-1:0]   pred_tag;
    logic [INDEX_WIDTH-1:0] upd_idx;
    logic [TAG_WIDTH-1:0]   upd_tag;
    logic                   upd_hit;
    logic [1:0]             upd_cnt_next;
    upd_kind_e              upd_kind;

    // The low two PC bits are always zero for RV32 fetch and are ignored.
    logic unused_upd_bits;
    assign unused_upd_bits = ^upd_pc[1:0];

    assign pred_idx = pred_pc[IDX_MSB:IDX_LSB];
    assign pred_tag = pred_pc[TAG_MSB:TAG_LSB];
    assign upd_idx  = upd_pc[IDX_MSB:IDX_LSB];
    assign upd_tag  = upd_pc[TAG_MSB:TAG_LSB];

    // Prediction reads stored state only, so a same-cycle update is not visible yet.
    always_comb begin
        pred_hit     = valid_q[pred_idx] && (tag_q[pred_idx] == pred_tag);
        pred_taken   = pred_hit && counter_q[pred_idx][1];
        pred_next_pc = pred_taken ? target_q[pred_idx] : pred_pc + XLEN'(4);
    end

    // Decode the update: hit detection, kind, and the saturated counter value.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        upd_hit      = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        upd_kind     = UPD_IDLE;
        upd_cnt_next = counter_q[upd_idx];
        if (upd_valid) begin
            if (upd_is_jump)        upd_kind = UPD_JUMP;
            else if (upd_is_branch) upd_kind = UPD_BRANCH;
            else                    upd_kind = UPD_OTHER;
        end
        if (upd_taken) begin
            if (counter_q[upd_idx] != 2'b11) upd_cnt_next = counter_q[upd_idx] + 2'd1;
        end else begin
            if (counter_q[upd_idx] != 2'b00) upd_cnt_next = counter_q[upd_idx] - 2'd1;
        end
    end

    // Table state: reset beats flush, flush beats (and drops) any update.
    always_ff @(posedge clk) begin
        // NOTE: the whole table is reset because the counters have a defined reset value.
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                // NOTE: sequential state uses non-blocking assignments only.
                valid_q[i]   <= 1'b0;
                tag_q[i]     <= '0;
                target_q[i]  <= '0;
                counter_q[i] <= CNT_RESET;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else begin
            unique case (upd_kind)
                UPD_JUMP: begin
                    valid_q[upd_idx]   <= 1'b1;
                    tag_q[upd_idx]     <= upd_tag;
                    target_q[upd_idx]  <= upd_target;
                    counter_q[upd_idx] <= CNT_JUMP;
                end
                UPD_BRANCH: begin
                    if (upd_hit) begin
                        counter_q[upd_idx] <= upd_cnt_next;
                        if (upd_taken) target_q[upd_idx] <= upd_target;
                    end else if (upd_taken) begin
                        valid_q[upd_idx]   <= 1'b1;
                        tag_q[upd_idx]     <= upd_tag;
                        target_q[upd_idx]  <= upd_target;
                        counter_q[upd_idx] <= CNT_ALLOC;
                    end
                end
                UPD_OTHER: begin
                    // A non-control instruction matching an entry means the entry is stale.
                    if (upd_hit) valid_q[upd_idx] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer.
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] pred_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_next_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_branch;
    logic        upd_is_jump;
    logic        upd_taken;
    logic [31:0] upd_target;

    int checks = 0;
    int errors = 0;

    branch_target_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .pred_pc      (pred_pc),
        .pred_hit     (pred_hit),
        .pred_taken   (pred_taken),
        .pred_next_pc (pred_next_pc),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_is_branch(upd_is_branch),
        .upd_is_jump  (upd_is_jump),
        .upd_taken    (upd_taken),
        .upd_target   (upd_target)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a fetch PC and compare all three prediction outputs.
    task automatic predict(input string tag, input logic [31:0] pc,
                           input logic hit, input logic taken, input logic [31:0] next_pc);
        pred_pc = pc;
        #1;
        check({tag, ".hit"},   {31'd0, pred_hit},   {31'd0, hit});
        check({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, taken});
        check({tag, ".next"},  pred_next_pc,        next_pc);
    endtask

    // Drive one update for exactly one rising edge.
    task automatic upd(input logic [31:0] pc, input logic br, input logic jmp,
                       input logic taken, input logic [31:0] tgt);
        @(negedge clk);
        upd_valid     = 1'b1;
        upd_pc        = pc;
        upd_is_branch = br;
        upd_is_jump   = jmp;
        upd_taken     = taken;
        upd_target    = tgt;
        @(negedge clk);
        upd_valid     = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; pred_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_is_branch = 1'b0; upd_is_jump = 1'b0;
        upd_taken = 1'b0; upd_target = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state, including wrap-around of pred_pc+4.
        predict("rst_40",   32'h40,       1'b0, 1'b0, 32'h44);
        predict("rst_0",    32'h0,        1'b0, 1'b0, 32'h4);
        predict("rst_wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

        // Allocate a taken branch: counter 10.
        upd(32'h40, 1, 0, 1, 32'h100);
        predict("alloc", 32'h40, 1'b1, 1'b1, 32'h100);
        // Not-taken training: 10 -> 01 -> 00 -> 00.
        upd(32'h40, 1, 0, 0, 32'h0);
        predict("nt1", 32'h40, 1'b1, 1'b0, 32'h44);
        upd(32'h40, 1, 0, 0, 32'h0);
        predict("nt2", 32'h40, 1'b1, 1'b0, 32'h44);
        upd(32'h40, 1, 0, 0, 32'h0);
        predict("nt3", 32'h40, 1'b1, 1'b0, 32'h44);
        // Taken training: 00 -> 01 -> 10 -> 11 -> 11.
        upd(32'h40, 1, 0, 1, 32'h100);
        predict("t1", 32'h40, 1'b1, 1'b0, 32'h44);
        upd(32'h40, 1, 0, 1, 32'h100);
        predict("t2", 32'h40, 1'b1, 1'b1, 32'h100);
        upd(32'h40, 1, 0, 1, 32'h100);
        predict("t3", 32'h40, 1'b1, 1'b1, 32'h100);
        upd(32'h40, 1, 0, 1, 32'h104);
        predict("t4", 32'h40, 1'b1, 1'b1, 32'h104);
        // Saturated at 11: one not-taken leaves 10 (still taken), another gives 01.
        upd(32'h40, 1, 0, 0, 32'h0);
        predict("sat_nt1", 32'h40, 1'b1, 1'b1, 32'h104);
        upd(32'h40, 1, 0, 0, 32'h0);
        predict("sat_nt2", 32'h40, 1'b1, 1'b0, 32'h44);

        // Aliasing at index 16: 0xC0 (tag 1) evicts 0x40 (tag 0).
        upd(32'hC0, 1, 0, 1, 32'h200);
        predict("alias_c0", 32'hC0, 1'b1, 1'b1, 32'h200);
        predict("alias_40", 32'h40, 1'b0, 1'b0, 32'h44);
        upd(32'h140, 1, 0, 0, 32'h999);
        predict("ntmiss_c0",  32'hC0,  1'b1, 1'b1, 32'h200);
        predict("ntmiss_140", 32'h140, 1'b0, 1'b0, 32'h144);

        // Jump allocates with counter 11: a not-taken branch leaves it taken.
        upd(32'h80, 0, 1, 1, 32'h10);
        predict("jump", 32'h80, 1'b1, 1'b1, 32'h10);
        upd(32'h80, 1, 0, 0, 32'h0);
        predict("jump_cnt", 32'h80, 1'b1, 1'b1, 32'h10);
        // Non-control hit invalidates; non-control miss changes nothing.
        upd(32'h80, 0, 0, 0, 32'h0);
        predict("nonctl_hit", 32'h80, 1'b0, 1'b0, 32'h84);
        upd(32'h140, 0, 0, 0, 32'h0);
        predict("nonctl_miss", 32'hC0, 1'b1, 1'b1, 32'h200);
        // Both flags set behaves as a jump, even with upd_taken low.
        upd(32'h100, 1, 1, 0, 32'h20);
        predict("both", 32'h100, 1'b1, 1'b1, 32'h20);

        // Same-cycle read of the index being written returns old contents.
        upd(32'h40, 1, 0, 1, 32'h100);
        predict("rw_setup", 32'h40, 1'b1, 1'b1, 32'h100);
        @(negedge clk);
        upd_valid = 1'b1; upd_pc = 32'h40; upd_is_branch = 1'b1; upd_is_jump = 1'b0;
        upd_taken = 1'b1; upd_target = 32'h300;
        predict("rw_old", 32'h40, 1'b1, 1'b1, 32'h100);
        @(negedge clk);
        upd_valid = 1'b0;
        predict("rw_new", 32'h40, 1'b1, 1'b1, 32'h300);

        // Flush clears every entry and drops the concurrent update.
        @(negedge clk);
        flush = 1'b1; upd_valid = 1'b1; upd_pc = 32'h60; upd_is_branch = 1'b1;
        upd_is_jump = 1'b0; upd_taken = 1'b1; upd_target = 32'h400;
        @(negedge clk);
        flush = 1'b0; upd_valid = 1'b0;
        predict("flush_40",  32'h40,  1'b0, 1'b0, 32'h44);
        predict("flush_100", 32'h100, 1'b0, 1'b0, 32'h104);
        predict("flush_60",  32'h60,  1'b0, 1'b0, 32'h64);
        // Re-allocation after flush uses counter 10: one not-taken drops to 01.
        upd(32'h60, 1, 0, 1, 32'h400);
        predict("realloc", 32'h60, 1'b1, 1'b1, 32'h400);
        upd(32'h60, 1, 0, 0, 32'h0);
        predict("realloc_nt", 32'h60, 1'b1, 1'b0, 32'h64);

        // Reset mid-stream clears the table and discards a concurrent jump.
        @(negedge clk);
        reset = 1'b1; upd_valid = 1'b1; upd_pc = 32'h80; upd_is_branch = 1'b0;
        upd_is_jump = 1'b1; upd_taken = 1'b1; upd_target = 32'h10;
        @(negedge clk);
        reset = 1'b0; upd_valid = 1'b0;
        predict("rst2_60", 32'h60, 1'b0, 1'b0, 32'h64);
        predict("rst2_80", 32'h80, 1'b0, 1'b0, 32'h84);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Parametrised direct-mapped branch target buffer for the pipelined RV32 core's IF stage. Each entry holds a valid bit, tag, target and a 2-bit saturating direction counter. It gives a same-cycle combinational next-PC prediction for the fetch PC and is updated from EX when a control-flow instruction resolves. Unlike a bare tag table, it writes only on qualified updates, keeps per-entry valid bits, supports flush, and invalidates entries on non-control aliasing.

## Interface
- XLEN, 32, PC and target width
- INDEX_WIDTH, 5, index bits; depth = 2**INDEX_WIDTH entries
- TAG_WIDTH, 25, tag bits; INDEX_WIDTH+TAG_WIDTH+2 <= XLEN required (elaboration error otherwise)

- clk  input  1  clock; all state changes on posedge
- reset  input  1  reset, synchronous, active-high
- flush  input  1  invalidate all entries
- pred_pc  input  XLEN  fetch PC to predict
- pred_hit  output  1  valid entry with matching tag
- pred_taken  output  1  pred_hit and counter[1]==1
- pred_next_pc  output  XLEN  pred_taken ? stored target : pred_pc+4
- upd_valid  input  1  resolved instruction present this cycle
- upd_pc  input  XLEN  PC of resolved instruction
- upd_is_branch  input  1  conditional branch
- upd_is_jump  input  1  JAL/JALR
- upd_taken  input  1  actual direction (jumps: 1)
- upd_target  input  XLEN  actual target

## Operation
- Address split: pc[1:0] ignored; index = pc[INDEX_WIDTH+1:2]; tag = pc[INDEX_WIDTH+TAG_WIDTH+1:INDEX_WIDTH+2].
- Prediction is purely combinational from stored state. pred_next_pc uses XLEN-bit wrap-around addition.
- An update is qualified by upd_valid. The update hit condition is valid[idx] && tag[idx]==upd_tag.
- Branch, hit: counter increments when taken and decrements when not taken, saturating at 2'b11 and 2'b00. If taken, target is overwritten.
- Branch, miss, taken: allocate the entry (overwrites any alias). Set valid=1, write the tag and target, and set counter=2'b10.
- Branch, miss, not taken: no state change.
- Jump, hit or miss: valid=1, write tag and target, counter=2'b11.
- Neither branch nor jump, hit: clear valid[idx] (stale alias removal). On a miss, nothing changes.
- upd_is_branch and upd_is_jump both 1 is treated as a jump.
- Flush: all valid bits are cleared. Tags, targets and counters are retained. Flush has priority over an update in the same cycle, and that update is dropped.
- Reset: all valid=0, counters=2'b01, tags=0, targets=0. Reset has priority over flush and update.

## Timing
- Prediction has zero latency: outputs follow pred_pc and state in the same cycle.
- An update committed at posedge N is visible to prediction from cycle N+1. There is no write-to-read bypass. A same-cycle read of the updated index returns old contents.
- Flush and reset take effect at the next posedge. In the cycle after, pred_hit=0, pred_taken=0 and pred_next_pc=pred_pc+4 for every pred_pc.
- Outputs after reset: pred_hit=0, pred_taken=0, pred_next_pc=pred_pc+4.
- Reset asserted mid-stream discards any concurrent update.

## Test plan
- Reset, then pred_pc=0x40 -> pred_hit=0, pred_taken=0, pred_next_pc=0x44.
- Branch update pc=0x40, taken, target=0x100. Next cycle pred_pc=0x40 -> hit=1, taken=1, next_pc=0x100. Two not-taken updates -> counter 10→01→00, pred_taken=0, next_pc=0x44, hit=1. Three taken updates -> counter 11 and saturates.
- Alias: entry for 0x40 is valid. Update a taken branch at pc=0xC0 (same index 16, tag 1), target=0x200 -> pred 0xC0 gives hit with next_pc=0x200, pred 0x40 gives hit=0. A not-taken miss at 0x140 leaves the 0xC0 entry intact.
- Jump at pc=0x80, target=0x10 -> counter=11, pred next_pc=0x10. A non-control update at pc=0x80 -> next cycle hit=0.
- Same-cycle read/write: pred_pc=upd_pc=0x40 with a taken update to 0x300 -> that cycle shows the old prediction, the next cycle shows 0x300.
- Flush together with a taken update at 0x60 -> all hits 0 next cycle, and 0x60 is not allocated. A subsequent taken update re-allocates it with counter=10.
